// File: rtl/pdpm_resp_tx.sv
// PDPM response transmitter: turns a response descriptor plus a 32-bit payload
// word stream into an 8-byte header followed by an MSB-first byte stream.
module pdpm_resp_tx #(
  parameter int unsigned MAX_LEN    = 1024,
  parameter logic [7:0]  ERR_STATUS = 8'hFE
) (
  input  logic        m_axis_aclk,
  input  logic        m_axis_aresetn,
  input  logic        desc_valid,
  output logic        desc_ready,
  input  logic [7:0]  desc_opcode,
  input  logic [7:0]  desc_status,
  input  logic [31:0] desc_addr,
  input  logic [15:0] desc_len,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [15:0] frames_sent,
  output logic [15:0] err_frames
);

  localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, HDR, PAY, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [2:0]  hdr_idx_q, hdr_idx_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  status_q, status_d;
  logic [15:0] len_q, len_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic [15:0] bytes_left_q, bytes_left_d;
  logic [13:0] words_left_q, words_left_d;
  logic [1:0]  byte_sel_q, byte_sel_d;
  logic [31:0] buf_q, buf_d;
  logic        buf_valid_q, buf_valid_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        desc_ready_q, desc_ready_d;
  logic [15:0] frames_q, frames_d;
  logic [15:0] err_frames_q, err_frames_d;

  logic        m_fire, out_free, last_in_word, advance, s_ready, s_fire, len_over;
  logic [2:0]  hdr_idx_n;
  logic [7:0]  hdr_byte, pay_byte;

  assign m_fire       = tvalid_q & m_axis_tready;
  assign out_free     = ~tvalid_q | m_axis_tready;
  assign last_in_word = (byte_sel_q == 2'd3) | (bytes_left_q == 16'd1);
  assign advance      = (state_q == PAY) & out_free & buf_valid_q;
  // Refill the buffer when empty or when its last used byte leaves this cycle.
  assign s_ready      = ((state_q == PAY) & (words_left_q != 14'd0) &
                         (~buf_valid_q | (advance & last_in_word))) |
                        (state_q == DRAIN);
  assign s_fire       = s_ready & s_axis_tvalid;
  assign len_over     = {1'b0, desc_len} > MAX_LEN_W;
  assign hdr_idx_n    = 3'(hdr_idx_q + 3'd1);

  always_comb begin
    hdr_byte = opcode_q;
    case (hdr_idx_n)
      3'd1:    hdr_byte = status_q;
      3'd2:    hdr_byte = len_q[15:8];
      3'd3:    hdr_byte = len_q[7:0];
      3'd4:    hdr_byte = addr_q[31:24];
      3'd5:    hdr_byte = addr_q[23:16];
      3'd6:    hdr_byte = addr_q[15:8];
      3'd7:    hdr_byte = addr_q[7:0];
      default: hdr_byte = opcode_q;
    endcase
  end

  always_comb begin
    pay_byte = buf_q[31:24];
    case (byte_sel_q)
      2'd1:    pay_byte = buf_q[23:16];
      2'd2:    pay_byte = buf_q[15:8];
      2'd3:    pay_byte = buf_q[7:0];
      default: pay_byte = buf_q[31:24];
    endcase
  end

  // Next-state and datapath.
  always_comb begin
    state_d      = state_q;
    hdr_idx_d    = hdr_idx_q;
    opcode_d     = opcode_q;
    status_d     = status_q;
    len_d        = len_q;
    addr_d       = addr_q;
    err_d        = err_q;
    bytes_left_d = bytes_left_q;
    words_left_d = words_left_q;
    byte_sel_d   = byte_sel_q;
    buf_d        = buf_q;
    buf_valid_d  = buf_valid_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    frames_d     = frames_q;
    err_frames_d = err_frames_q;

    if (m_fire && tlast_q) frames_d = 16'(frames_q + 16'd1);

    case (state_q)
      IDLE: begin
        if (desc_valid && desc_ready_q) begin
          state_d      = HDR;
          opcode_d     = desc_opcode;
          addr_d       = desc_addr;
          err_d        = len_over;
          status_d     = len_over ? ERR_STATUS : desc_status;
          len_d        = len_over ? 16'd0 : desc_len;
          bytes_left_d = desc_len;
          words_left_d = 14'((17'(desc_len) + 17'd3) >> 2);
          hdr_idx_d    = 3'd0;
          byte_sel_d   = 2'd0;
          buf_valid_d  = 1'b0;
          tdata_d      = desc_opcode;
          tvalid_d     = 1'b1;
          tlast_d      = 1'b0;
        end
      end
      HDR: begin
        if (m_fire) begin
          if (hdr_idx_q == 3'd7) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            if (err_q) begin
              state_d      = DRAIN;
              err_frames_d = 16'(err_frames_q + 16'd1);
            end else if (len_q == 16'd0) begin
              state_d = IDLE;
            end else begin
              state_d = PAY;
            end
          end else begin
            hdr_idx_d = hdr_idx_n;
            tdata_d   = hdr_byte;
            tlast_d   = (hdr_idx_n == 3'd7) && (len_q == 16'd0);
          end
        end
      end
      PAY: begin
        if (m_fire && tlast_q) begin
          state_d  = IDLE;
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end else if (advance) begin
          tdata_d      = pay_byte;
          tvalid_d     = 1'b1;
          tlast_d      = (bytes_left_q == 16'd1);
          bytes_left_d = 16'(bytes_left_q - 16'd1);
          byte_sel_d   = 2'(byte_sel_q + 2'd1);
          if (last_in_word) begin
            buf_valid_d = 1'b0;
            byte_sel_d  = 2'd0;
          end
        end else if (out_free) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end
        if (s_fire) begin
          buf_d        = s_axis_tdata;
          buf_valid_d  = 1'b1;
          byte_sel_d   = 2'd0;
          words_left_d = 14'(words_left_q - 14'd1);
        end
      end
      DRAIN: begin
        if (s_fire) begin
          if (bytes_left_q <= 16'd4) state_d = IDLE;
          else bytes_left_d = 16'(bytes_left_q - 16'd4);
        end
      end
      default: state_d = IDLE;
    endcase

    desc_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_q      <= IDLE;
      hdr_idx_q    <= 3'd0;
      opcode_q     <= 8'd0;
      status_q     <= 8'd0;
      len_q        <= 16'd0;
      addr_q       <= 32'd0;
      err_q        <= 1'b0;
      bytes_left_q <= 16'd0;
      words_left_q <= 14'd0;
      byte_sel_q   <= 2'd0;
      buf_q        <= 32'd0;
      buf_valid_q  <= 1'b0;
      tdata_q      <= 8'd0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      desc_ready_q <= 1'b0;
      frames_q     <= 16'd0;
      err_frames_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      hdr_idx_q    <= hdr_idx_d;
      opcode_q     <= opcode_d;
      status_q     <= status_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      err_q        <= err_d;
      bytes_left_q <= bytes_left_d;
      words_left_q <= words_left_d;
      byte_sel_q   <= byte_sel_d;
      buf_q        <= buf_d;
      buf_valid_q  <= buf_valid_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      desc_ready_q <= desc_ready_d;
      frames_q     <= frames_d;
      err_frames_q <= err_frames_d;
    end
  end

  assign desc_ready    = desc_ready_q;
  assign s_axis_tready = s_ready;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign frames_sent   = frames_q;
  assign err_frames    = err_frames_q;

endmodule

// File: tb/tb_pdpm_resp_tx.sv
// Scoreboard bench for pdpm_resp_tx: expected bytes are queued per descriptor
// and compared as the DUT hands them downstream.
module tb_pdpm_resp_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [7:0]  desc_opcode = 8'd0;
  logic [7:0]  desc_status = 8'd0;
  logic [31:0] desc_addr = 32'd0;
  logic [15:0] desc_len = 16'd0;
  logic [31:0] s_axis_tdata = 32'd0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic [15:0] frames_sent;
  logic [15:0] err_frames;

  pdpm_resp_tx #(.MAX_LEN(1024), .ERR_STATUS(8'hFE)) dut (
    .m_axis_aclk   (clk),
    .m_axis_aresetn(rst_n),
    .desc_valid    (desc_valid),
    .desc_ready    (desc_ready),
    .desc_opcode   (desc_opcode),
    .desc_status   (desc_status),
    .desc_addr     (desc_addr),
    .desc_len      (desc_len),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .frames_sent   (frames_sent),
    .err_frames    (err_frames)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  logic [8:0]  sb_q[$];
  logic [31:0] src_q[$];
  logic [31:0] pay_words[$];
  int          word_cnt = 0;
  int          exp_words = 0;
  int          exp_frames = 0;
  int          exp_err = 0;
  int          frame_bytes = 0;
  int          cyc = 0;
  int          tlast_cyc = 0;
  int          first_gap = -1;
  bit          new_frame = 1'b1;
  bit          s_fire_seen = 1'b0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'd0;
  logic        prev_last = 1'b0;
  bit          rnd_ready = 1'b0;
  int unsigned s_gap = 0;

  // Monitor: sample at the falling edge what the next rising edge will see.
  initial forever begin
    logic [8:0] e;
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      if (prev_stall) begin
        check("hold_valid", 32'(m_axis_tvalid), 32'd1);
        check("hold_data", 32'(m_axis_tdata), 32'(prev_data));
        check("hold_last", 32'(m_axis_tlast), 32'(prev_last));
      end
      if (m_axis_tvalid && new_frame) begin
        first_gap = cyc - tlast_cyc;
        new_frame = 1'b0;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb_q.size() == 0) begin
          check("sb_nonempty", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check("byte", 32'({m_axis_tlast, m_axis_tdata}), 32'(e));
        end
        frame_bytes++;
        if (m_axis_tlast) begin
          frame_bytes = 0;
          tlast_cyc = cyc;
          new_frame = 1'b1;
        end
      end
      if (s_axis_tvalid && s_axis_tready) begin
        word_cnt++;
        s_fire_seen = 1'b1;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Payload source and downstream ready generator.
  initial forever begin
    @(posedge clk);
    #1;
    m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (s_fire_seen) begin
      void'(src_q.pop_front());
      s_fire_seen = 1'b0;
      s_axis_tvalid = 1'b0;
    end
    if (!s_axis_tvalid && src_q.size() > 0 && $urandom_range(0, 99) >= s_gap) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = src_q[0];
    end
  end

  task automatic send_desc(input logic [7:0] op, input logic [7:0] st,
                           input logic [31:0] addr, input logic [15:0] len);
    int          nw;
    bit          over;
    bit          ok;
    logic [15:0] hl;
    logic [7:0]  hb[8];
    logic [31:0] sh;
    nw   = (int'(len) + 3) / 4;
    over = int'(len) > 1024;
    hl   = over ? 16'h0000 : len;
    hb[0] = op;
    hb[1] = over ? 8'hFE : st;
    hb[2] = hl[15:8];
    hb[3] = hl[7:0];
    hb[4] = addr[31:24];
    hb[5] = addr[23:16];
    hb[6] = addr[15:8];
    hb[7] = addr[7:0];
    for (int i = 0; i < 8; i++) sb_q.push_back({(i == 7) && (hl == 16'd0), hb[i]});
    while (pay_words.size() < nw) pay_words.push_back($urandom);
    for (int w = 0; w < nw; w++) src_q.push_back(pay_words[w]);
    if (!over) begin
      for (int b = 0; b < int'(len); b++) begin
        sh = pay_words[b / 4] >> (8 * (3 - (b % 4)));
        sb_q.push_back({b == int'(len) - 1, sh[7:0]});
      end
    end
    pay_words.delete();
    exp_words += nw;
    exp_frames++;
    if (over) exp_err++;
    @(posedge clk);
    #1;
    desc_opcode = op;
    desc_status = st;
    desc_addr   = addr;
    desc_len    = len;
    desc_valid  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (desc_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("desc_accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    desc_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #3;
      if (sb_q.size() == 0 && src_q.size() == 0 && desc_ready && !s_fire_seen) begin
        ok = 1'b1;
        break;
      end
    end
    check("frame_done", 32'(ok), 32'd1);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_words"}, 32'(word_cnt), 32'(exp_words));
    check({tag, "_frames"}, 32'(frames_sent), 32'(exp_frames));
    check({tag, "_errs"}, 32'(err_frames), 32'(exp_err));
  endtask

  initial begin
    bit ok;
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check("rst_s_tready", 32'(s_axis_tready), 32'd0);
    check("rst_desc_ready", 32'(desc_ready), 32'd0);
    check("rst_frames", 32'(frames_sent), 32'd0);
    check("rst_errs", 32'(err_frames), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_desc_ready", 32'(desc_ready), 32'd1);

    // Header-only frame.
    send_desc(8'h02, 8'h00, 32'h0000_1000, 16'd0);
    wait_done(200);
    check_counts("len0");

    // Six bytes from two words, trailing bytes discarded.
    pay_words.push_back(32'hA1A2_A3A4);
    pay_words.push_back(32'hB1B2_B3B4);
    send_desc(8'h10, 8'h00, 32'hDEAD_BEEF, 16'd6);
    wait_done(200);
    check_counts("len6");

    // Word-aligned and odd lengths.
    send_desc(8'h20, 8'h01, 32'h0102_0304, 16'd4);
    wait_done(200);
    send_desc(8'h21, 8'h02, 32'h0506_0708, 16'd7);
    wait_done(200);
    check_counts("len4_7");

    // Maximum legal length under random backpressure and source gaps.
    rnd_ready = 1'b1;
    s_gap = 30;
    send_desc(8'h11, 8'h5A, 32'h1234_5678, 16'd1024);
    wait_done(12000);
    rnd_ready = 1'b0;
    s_gap = 0;
    check_counts("len1024");

    // Oversize descriptors are rejected and drained.
    send_desc(8'h12, 8'h33, 32'hCAFE_F00D, 16'd2000);
    wait_done(3000);
    check_counts("len2000");
    send_desc(8'h13, 8'h44, 32'h0000_0040, 16'd5);
    wait_done(200);
    send_desc(8'h14, 8'h55, 32'h0000_0080, 16'd1025);
    wait_done(2000);
    check_counts("after_err");

    // Back-to-back descriptors.
    send_desc(8'h30, 8'h00, 32'h0000_0100, 16'd3);
    send_desc(8'h31, 8'h00, 32'h0000_0200, 16'd0);
    wait_done(200);
    check("b2b_gap", 32'(first_gap), 32'd2);
    check_counts("b2b");

    // Reset in the middle of a payload.
    send_desc(8'h40, 8'h00, 32'h0000_0300, 16'd16);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #3;
      if (frame_bytes == 10 && m_axis_tvalid) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_pay3", 32'(ok), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("mid_rst_tlast", 32'(m_axis_tlast), 32'd0);
    check("mid_rst_desc_ready", 32'(desc_ready), 32'd0);
    check("mid_rst_s_tready", 32'(s_axis_tready), 32'd0);
    sb_q.delete();
    src_q.delete();
    s_axis_tvalid = 1'b0;
    s_fire_seen = 1'b0;
    frame_bytes = 0;
    new_frame = 1'b1;
    word_cnt = 0;
    exp_words = 0;
    exp_frames = 0;
    exp_err = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_desc_ready", 32'(desc_ready), 32'd1);
    check("rel_frames", 32'(frames_sent), 32'd0);
    check("rel_errs", 32'(err_frames), 32'd0);
    send_desc(8'h50, 8'h07, 32'h0000_0400, 16'd5);
    wait_done(200);
    check_counts("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
